logic_unit_pipe: RTL and testbench



---
 rtl/logic_unit_pipe_pkg.sv | 31 +++
 rtl/logic_unit_core.sv | 42 ++++
 rtl/logic_unit_pipe.sv | 119 +++++++++++
 tb/tb_logic_unit_pipe.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pipe_pkg.sv
// ============================================================================
// Module      : logic_unit_pipe_pkg
// Description : Shared op codes, field widths and defaults for the ALU logic
//               unit and its pipelined wrapper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package logic_unit_pipe_pkg;

  // Width of the operation select field
  localparam int OP_W = 3;

  // Default operand/result width
  localparam int DEFAULT_WIDTH = 16;

  // Operation encoding
  typedef enum logic [OP_W-1:0] {
    OP_NOT  = 3'd0,
    OP_AND  = 3'd1,
    OP_OR   = 3'd2,
    OP_XOR  = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_PASS = 3'd7
  } op_e;

endpackage

`default_nettype wire

// File: rtl/logic_unit_core.sv
// ============================================================================
// Module      : logic_unit_core
// Description : Combinational bitwise logic slice: {op, a, b} -> {result,
//               zero, parity}. Shared by ALU slices, so it carries no state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_unit_core
  import logic_unit_pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [OP_W-1:0]  op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             parity_o
);

  // Select the bitwise function; b is don't-care for NOT and PASS
  always_comb begin
    result_o = a_i;
    case (op_e'(op_i))
      OP_NOT:  result_o = ~a_i;
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_NAND: result_o = ~(a_i & b_i);
      OP_NOR:  result_o = ~(a_i | b_i);
      OP_XNOR: result_o = ~(a_i ^ b_i);
      OP_PASS: result_o = a_i;
    endcase
  end

  assign zero_o   = (result_o == '0);
  assign parity_o = ^result_o;

endmodule

`default_nettype wire

// File: rtl/logic_unit_pipe.sv
// ============================================================================
// Module      : logic_unit_pipe
// Description : Pipelined bitwise logic unit with valid/ready handshaking on
//               both sides, zero/parity flags and a saturating count of
//               consumed results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_unit_pipe
  import logic_unit_pipe_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity,
  output logic [CNT_W-1:0] done_count
);

  // Stage word layout: {result, zero, parity}
  localparam int WORD_W = WIDTH + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  generate
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("logic_unit_pipe: STAGES must be in 1..4");
    end
  endgenerate

  logic [WIDTH-1:0]  core_result;
  logic              core_zero;
  logic              core_parity;
  logic [STAGES-1:0] valid_q;
  logic [WORD_W-1:0] data_q [STAGES];
  logic [STAGES-1:0] advance;
  logic [CNT_W-1:0]  done_count_q;
  logic [CNT_W-1:0]  done_count_d;
  logic              out_xfer;

  logic_unit_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op_i     (op),
    .a_i      (a),
    .b_i      (b),
    .result_o (core_result),
    .zero_o   (core_zero),
    .parity_o (core_parity)
  );

  // A stage may advance when it or any stage downstream of it holds a bubble,
  // or when the consumer takes the head; written as a flat reduction so the
  // ready chain has no combinational self-reference.
  generate
    for (genvar i = 0; i < STAGES; i++) begin : g_advance
      assign advance[i] = out_ready || !(&valid_q[STAGES-1:i]);
    end
  endgenerate

  assign in_ready  = advance[0];
  assign out_valid = valid_q[STAGES-1];
  assign {result, zero, parity} = data_q[STAGES-1];
  assign out_xfer  = out_valid && out_ready;

  // Pipeline registers: stage 0 captures the computed word, later stages delay it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      if (advance[0]) begin
        valid_q[0] <= in_valid;
        data_q[0]  <= {core_result, core_zero, core_parity};
      end
      for (int i = 1; i < STAGES; i++) begin
        if (advance[i]) begin
          valid_q[i] <= valid_q[i-1];
          data_q[i]  <= data_q[i-1];
        end
      end
    end
  end

  // Saturating count of results handed to the consumer
  always_comb begin
    done_count_d = done_count_q;
    if (out_xfer && (done_count_q != CNT_MAX)) begin
      done_count_d = done_count_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_count_q <= '0;
    end else begin
      done_count_q <= done_count_d;
    end
  end

  assign done_count = done_count_q;

endmodule

`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
// ============================================================================
// Module      : tb_logic_unit_pipe
// Description : Directed self-checking bench for logic_unit_pipe: a 2-stage
//               unit, a 4-stage unit for streaming and a 1-stage unit with a
//               4-bit counter for saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_logic_unit_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  op;
  logic [15:0] a, b;

  // 2-stage unit
  logic        v2, r2, ir2, ov2, z2, p2;
  logic [15:0] res2;
  logic [15:0] dc2;
  // 4-stage unit
  logic        v4, r4, ir4, ov4, z4, p4;
  logic [15:0] res4;
  logic [15:0] dc4;
  // 1-stage unit, 4-bit counter
  logic        vs, rs, irs, ovs, zs, ps;
  logic [15:0] ress;
  logic [3:0]  dcs;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(16), .STAGES(2), .CNT_W(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(ir2), .op(op), .a(a), .b(b),
    .out_valid(ov2), .out_ready(r2), .result(res2), .zero(z2), .parity(p2),
    .done_count(dc2)
  );

  logic_unit_pipe #(.WIDTH(16), .STAGES(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(ir4), .op(op), .a(a), .b(b),
    .out_valid(ov4), .out_ready(r4), .result(res4), .zero(z4), .parity(p4),
    .done_count(dc4)
  );

  logic_unit_pipe #(.WIDTH(16), .STAGES(1), .CNT_W(4)) duts (
    .clk(clk), .rst_n(rst_n), .in_valid(vs), .in_ready(irs), .op(op), .a(a), .b(b),
    .out_valid(ovs), .out_ready(rs), .result(ress), .zero(zs), .parity(ps),
    .done_count(dcs)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: returns {result, zero, parity}
  function automatic logic [17:0] model(input logic [2:0] o, input logic [15:0] x,
                                        input logic [15:0] y);
    logic [15:0] r;
    case (o)
      3'd0: r = ~x;
      3'd1: r = x & y;
      3'd2: r = x | y;
      3'd3: r = x ^ y;
      3'd4: r = ~(x & y);
      3'd5: r = ~(x | y);
      3'd6: r = ~(x ^ y);
      default: r = x;
    endcase
    return {r, (r == 16'h0), ^r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [17:0] sb [$];
    logic [17:0] e;
    int acc, got, cyc;

    rst_n = 1'b0;
    v2 = 0; r2 = 0; v4 = 0; r4 = 0; vs = 0; rs = 0;
    op = 3'd0; a = '0; b = '0;
    tick(); tick();
    rst_n = 1'b1;
    #1;

    // Reset state
    chk("rst_out_valid", ov2, 0);
    chk("rst_result", res2, 0);
    chk("rst_zero", z2, 0);
    chk("rst_parity", p2, 0);
    chk("rst_done_count", dc2, 0);
    chk("rst_in_ready", ir2, 1);

    // NOT 1559 -> EAA6, parity odd
    v2 = 1; r2 = 1; op = 3'd0; a = 16'h1559;
    #1 chk("not_in_ready", ir2, 1);
    tick();
    v2 = 0;
    chk("not_latency_not_yet", ov2, 0);
    tick();
    chk("not_out_valid", ov2, 1);
    chk("not_result", res2, 16'hEAA6);
    chk("not_zero", z2, 0);
    chk("not_parity", p2, 1);
    tick();

    // AND then XNOR back to back
    v2 = 1; op = 3'd1; a = 16'hFF00; b = 16'h00FF;
    tick();
    op = 3'd6; a = 16'hA5A5; b = 16'hA5A5;
    tick();
    v2 = 0;
    chk("and_out_valid", ov2, 1);
    chk("and_result", res2, 16'h0000);
    chk("and_zero", z2, 1);
    chk("and_parity", p2, 0);
    tick();
    chk("xnor_result", res2, 16'hFFFF);
    chk("xnor_zero", z2, 0);
    chk("xnor_parity", p2, 0);
    tick();
    chk("empty_after_xnor", ov2, 0);

    // Backpressure: only two fit while the consumer stalls
    r2 = 0; v2 = 1; op = 3'd2; a = 16'd1; b = 16'd2;
    #1 chk("bp_ready_1", ir2, 1);
    tick();
    a = 16'd4; b = 16'd8;
    #1 chk("bp_ready_2", ir2, 1);
    tick();
    a = 16'd16; b = 16'd32;
    #1 chk("bp_ready_3_full", ir2, 0);
    chk("bp_head_valid", ov2, 1);
    chk("bp_head_result", res2, 16'd3);
    tick();
    chk("bp_hold_result", res2, 16'd3);
    chk("bp_still_full", ir2, 0);
    r2 = 1;
    #1 chk("bp_full_drain_ready", ir2, 1);
    tick();
    v2 = 0;
    chk("bp_second", res2, 16'd12);
    tick();
    chk("bp_third", res2, 16'd48);
    tick();
    chk("bp_drained", ov2, 0);
    chk("bp_done_count", dc2, 6);

    // Streaming on the 4-stage unit with random handshakes
    acc = 0; got = 0; cyc = 0;
    while ((acc < 100 || got < 100) && cyc < 3000) begin
      v4 = (acc < 100) && ($urandom_range(0, 3) != 0);
      r4 = ($urandom_range(0, 2) != 0);
      op = 3'($urandom_range(0, 7));
      a  = 16'($urandom);
      b  = 16'($urandom);
      #1;
      if (ov4 && r4) begin
        if (sb.size() == 0) begin
          chk("stream_unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("stream_result", res4, e[17:2]);
          chk("stream_zero", z4, e[1]);
          chk("stream_parity", p4, e[0]);
        end
        got++;
      end
      if (v4 && ir4) begin
        sb.push_back(model(op, a, b));
        acc++;
      end
      tick();
      cyc++;
    end
    v4 = 0; r4 = 0;
    chk("stream_no_timeout", (cyc < 3000), 1);
    chk("stream_done_count", dc4, 100);
    chk("stream_scoreboard_empty", sb.size(), 0);

    // Saturation of a 4-bit counter
    vs = 1; rs = 1; op = 3'd7;
    for (int i = 0; i < 20; i++) begin
      a = 16'(i);
      tick();
    end
    vs = 0;
    tick(); tick(); tick();
    chk("sat_done_count", dcs, 15);
    tick(); tick();
    chk("sat_stays", dcs, 15);

    // Asynchronous reset with two results in flight
    r2 = 0; v2 = 1; op = 3'd3; a = 16'h00F0; b = 16'h0F00;
    tick(); tick();
    v2 = 0;
    chk("rst_mid_inflight", ov2, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", ov2, 0);
    chk("rst_mid_done_count", dc2, 0);
    chk("rst_mid_sat_count", dcs, 0);
    #2 rst_n = 1'b1;
    tick();
    r2 = 1;
    #1 chk("rst_mid_in_ready", ir2, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rst_no_stale", ov2, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
